// File: rtl/mult_seq_radix.sv
// Sequential shift-add multiplier retiring BITS_PER_CYCLE multiplier bits per clock (start/busy/done).
// Define MULT_SEQ_ACC_EN to add acc_op/acc_in for accumulate/subtract into {hi,lo}.
module mult_seq_radix #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic                 flush,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
`ifdef MULT_SEQ_ACC_EN
  input  logic [1:0]           acc_op,
  input  logic [2*WIDTH-1:0]   acc_in,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     hi,
  output logic [WIDTH-1:0]     lo
);

  localparam int ITER = WIDTH / BITS_PER_CYCLE;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t               state;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]     b_mag;
  logic [CW-1:0]        cnt;
  logic                 sign;
  logic [WIDTH-1:0]     a_abs, b_abs;
  logic [2*WIDTH-1:0]   addend, prod, result;
`ifdef MULT_SEQ_ACC_EN
  logic [1:0]           acc_op_q;
  logic [2*WIDTH-1:0]   acc_in_q;
`endif

  always_comb begin
    a_abs  = (is_signed && a[WIDTH-1]) ? -a : a;
    b_abs  = (is_signed && b[WIDTH-1]) ? -b : b;
    // a_sh already carries the current bit offset, so each digit bit adds a shifted copy
    addend = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      if (b_mag[i]) addend = addend + (a_sh << i);
    end
    prod   = sign ? -acc : acc;
    result = prod;
`ifdef MULT_SEQ_ACC_EN
    case (acc_op_q)
      2'b01:   result = acc_in_q + prod;
      2'b10:   result = acc_in_q - prod;
      default: result = prod;
    endcase
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      acc      <= '0;
      a_sh     <= '0;
      b_mag    <= '0;
      cnt      <= '0;
      sign     <= 1'b0;
`ifdef MULT_SEQ_ACC_EN
      acc_op_q <= '0;
      acc_in_q <= '0;
`endif
    end else if (flush) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh     <= (2*WIDTH)'(a_abs);
            b_mag    <= b_abs;
            sign     <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc      <= '0;
            cnt      <= CW'(ITER - 1);
            busy     <= 1'b1;
            state    <= RUN;
`ifdef MULT_SEQ_ACC_EN
            acc_op_q <= acc_op;
            acc_in_q <= acc_in;
`endif
          end
        end
        RUN: begin
          acc   <= acc + addend;
          a_sh  <= a_sh << BITS_PER_CYCLE;
          b_mag <= b_mag >> BITS_PER_CYCLE;
          if (cnt == '0) state <= FINISH;
          else           cnt   <= cnt - 1'b1;
        end
        FINISH: begin
          {hi, lo} <= result;
          busy     <= 1'b0;
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_radix.sv
// Self-checking bench for mult_seq_radix: three instances (1/2/4 bits per cycle) on shared stimulus.
// Fixed-vector table, hand-written handshake corner cases and random pairs against a 64-bit arithmetic model.
module tb_mult_seq_radix;

  logic        clk = 1'b0;
  logic        rst, start, is_signed, flush;
  logic [31:0] a, b;
  logic        busy_v[3], done_v[3];
  logic [31:0] hi_v[3], lo_v[3];
`ifdef MULT_SEQ_ACC_EN
  logic [1:0]  acc_op;
  logic [63:0] acc_in;
`endif

  int          n_vec = 0;
  int          n_mis = 0;
  int          iter_k[3] = '{32, 16, 8};
  logic [63:0] last_exp[3];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] p;
  } vec_t;
  vec_t tbl[8];

  always #5 clk = ~clk;

  mult_seq_radix #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_b1 (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed), .flush(flush),
    .a(a), .b(b),
`ifdef MULT_SEQ_ACC_EN
    .acc_op(acc_op), .acc_in(acc_in),
`endif
    .busy(busy_v[0]), .done(done_v[0]), .hi(hi_v[0]), .lo(lo_v[0]));

  mult_seq_radix #(.WIDTH(32), .BITS_PER_CYCLE(2)) u_b2 (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed), .flush(flush),
    .a(a), .b(b),
`ifdef MULT_SEQ_ACC_EN
    .acc_op(acc_op), .acc_in(acc_in),
`endif
    .busy(busy_v[1]), .done(done_v[1]), .hi(hi_v[1]), .lo(lo_v[1]));

  mult_seq_radix #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_b4 (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed), .flush(flush),
    .a(a), .b(b),
`ifdef MULT_SEQ_ACC_EN
    .acc_op(acc_op), .acc_in(acc_in),
`endif
    .busy(busy_v[2]), .done(done_v[2]), .hi(hi_v[2]), .lo(lo_v[2]));

  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic s,
                                        input logic [1:0] op, input logic [63:0] ai);
    logic [63:0] p;
    if (s) p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
    else   p = {32'd0, x} * {32'd0, y};
    case (op)
      2'b01:   p = ai + p;
      2'b10:   p = ai - p;
      default: ;
    endcase
    return p;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // One operation on all instances; optional ignored start at cycle inj, optional flush at cycle fl.
  task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                       input logic [63:0] exp, input int inj, input int fl, input string nm);
    int          lat[3], dc[3], bc[3];
    logic [63:0] res[3];
    string       tag;
    for (int k = 0; k < 3; k++) begin
      lat[k] = 0; dc[k] = 0; bc[k] = 0; res[k] = '0;
    end
    @(negedge clk);
    a = x; b = y; is_signed = s; start = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      for (int k = 0; k < 3; k++) begin
        if (busy_v[k]) bc[k]++;
        if (done_v[k]) begin
          dc[k]++;
          if (lat[k] == 0) begin
            lat[k] = cyc;
            res[k] = {hi_v[k], lo_v[k]};
          end
        end
      end
      if (cyc == inj) begin
        start = 1'b1; a = ~x; b = y + 32'd1; is_signed = ~s;
      end
      if (cyc == fl) flush = 1'b1;
    end
    for (int k = 0; k < 3; k++) begin
      tag = $sformatf("%s B%0d", nm, 32 / iter_k[k]);
      if (fl == 0) begin
        check({tag, " result"}, res[k], exp);
        check({tag, " latency"}, 64'(lat[k]), 64'(iter_k[k] + 2));
        check({tag, " busy_cycles"}, 64'(bc[k]), 64'(iter_k[k] + 1));
        check({tag, " done_pulses"}, 64'(dc[k]), 64'd1);
        last_exp[k] = exp;
      end else begin
        check({tag, " done_pulses"}, 64'(dc[k]), 64'd0);
        check({tag, " busy_cycles"}, 64'(bc[k]), 64'(fl));
      end
      check({tag, " hold"}, {hi_v[k], lo_v[k]}, last_exp[k]);
    end
  endtask

  // start coincident with the B=2 done pulse; B=4 is idle by then, B=1 is still busy.
  task automatic b2b(input logic [31:0] x1, input logic [31:0] y1,
                     input logic [31:0] x2, input logic [31:0] y2);
    logic [63:0] r1, r2;
    int          d1[3], d2[3], dn[3];
    logic [63:0] v1[3], v2[3];
    int          e_dn[3] = '{1, 2, 2};
    int          e_d2[3] = '{0, 36, 28};
    r1 = model(x1, y1, 1'b0, 2'b00, 64'd0);
    r2 = model(x2, y2, 1'b0, 2'b00, 64'd0);
    for (int k = 0; k < 3; k++) begin
      d1[k] = 0; d2[k] = 0; dn[k] = 0; v1[k] = '0; v2[k] = '0;
    end
    @(negedge clk);
    a = x1; b = y1; is_signed = 1'b0; start = 1'b1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
        if (done_v[k]) begin
          dn[k]++;
          if (dn[k] == 1) begin d1[k] = cyc; v1[k] = {hi_v[k], lo_v[k]}; end
          else            begin d2[k] = cyc; v2[k] = {hi_v[k], lo_v[k]}; end
        end
      end
      if (done_v[1] && d1[1] == cyc) begin
        start = 1'b1; a = x2; b = y2;
      end
    end
    for (int k = 0; k < 3; k++) begin
      check($sformatf("b2b B%0d done_pulses", 32 / iter_k[k]), 64'(dn[k]), 64'(e_dn[k]));
      check($sformatf("b2b B%0d first_done", 32 / iter_k[k]), 64'(d1[k]), 64'(iter_k[k] + 2));
      check($sformatf("b2b B%0d first_result", 32 / iter_k[k]), v1[k], r1);
      if (k > 0) begin
        check($sformatf("b2b B%0d second_done", 32 / iter_k[k]), 64'(d2[k]), 64'(e_d2[k]));
        check($sformatf("b2b B%0d second_result", 32 / iter_k[k]), v2[k], r2);
      end
    end
    last_exp[0] = r1; last_exp[1] = r2; last_exp[2] = r2;
    for (int k = 0; k < 3; k++)
      check($sformatf("b2b B%0d hold", 32 / iter_k[k]), {hi_v[k], lo_v[k]}, last_exp[k]);
  endtask

  initial begin
    logic [31:0] x, y;
    logic        s;
    logic [63:0] e;

    tbl[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001};
    tbl[1] = '{32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB};
    tbl[2] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000};
    tbl[3] = '{32'h0000_0000, 32'h1234_5678, 1'b1, 64'h0000_0000_0000_0000};
    tbl[4] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_8000_0000};
    tbl[5] = '{32'h8000_0000, 32'h0000_0002, 1'b0, 64'h0000_0001_0000_0000};
    tbl[6] = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 64'hC000_0000_8000_0000};
    tbl[7] = '{32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF};

    start = 1'b0; is_signed = 1'b0; flush = 1'b0; a = '0; b = '0;
`ifdef MULT_SEQ_ACC_EN
    acc_op = 2'b00; acc_in = '0;
`endif
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset B%0d hilo", 32 / iter_k[k]), {hi_v[k], lo_v[k]}, 64'd0);
      check($sformatf("reset B%0d busy_done", 32 / iter_k[k]), {62'd0, busy_v[k], done_v[k]}, 64'd0);
      last_exp[k] = '0;
    end
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) do_op(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].p, 0, 0, $sformatf("tbl%0d", i));

    do_op(32'h0000_1234, 32'h0000_5678, 1'b0, model(32'h1234, 32'h5678, 1'b0, 2'b00, 64'd0), 5, 0, "ignore_start");
    do_op(32'h0000_0005, 32'h0000_0006, 1'b0, 64'd30, 0, 7, "flush");
    b2b(32'hDEAD_BEEF, 32'h0000_0003, 32'h0001_0001, 32'hFFFF_0000);

    @(negedge clk);
    a = 32'h0000_00FF; b = 32'h0000_0101; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_mid B%0d hilo", 32 / iter_k[k]), {hi_v[k], lo_v[k]}, 64'd0);
      check($sformatf("rst_mid B%0d busy_done", 32 / iter_k[k]), {62'd0, busy_v[k], done_v[k]}, 64'd0);
      last_exp[k] = '0;
    end
    @(negedge clk);
    rst = 1'b0;

`ifdef MULT_SEQ_ACC_EN
    acc_op = 2'b10; acc_in = 64'h0000_0001_0000_0000;
    do_op(32'd2, 32'd3, 1'b1, 64'h0000_0000_FFFF_FFFA, 0, 0, "msub");
    acc_op = 2'b01; acc_in = 64'hFFFF_FFFF_FFFF_FFFF;
    do_op(32'd1, 32'd1, 1'b0, 64'h0000_0000_0000_0000, 0, 0, "maddu");
    acc_op = 2'b11; acc_in = 64'h1234_5678_9ABC_DEF0;
    do_op(32'd4, 32'd5, 1'b0, 64'd20, 0, 0, "acc_op11");
`endif

    for (int n = 0; n < 1000; n++) begin
      x = pick();
      y = pick();
      s = 1'($urandom_range(0, 1));
`ifdef MULT_SEQ_ACC_EN
      acc_op = 2'($urandom_range(0, 3));
      acc_in = {$urandom, $urandom};
      e = model(x, y, s, acc_op, acc_in);
`else
      e = model(x, y, s, 2'b00, 64'd0);
`endif
      do_op(x, y, s, e, 0, 0, $sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
